mem_responder: RTL and testbench

- Memory-side responder for the core's single memory port; services the address, write-data and write-enable requests the core drives.
- Returns read data on from_mem_data after a fixed, parameterised latency.
- Holds word storage plus two memory-mapped registers: a free-running cycle counter and an I/O output register.
- Sits at top level between the core and the board I/O.

---
 rtl/mem_responder.sv | 102 ++++++++++
 tb/tb_mem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: word storage, a free-running cycle counter and an I/O
// output register behind one address port, read data returned after READ_LATENCY cycles.
module mem_responder #(
    parameter int          ADDR_W       = 10,
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] CTR_ADDR     = 16'hFFFE,
    parameter logic [15:0] IO_ADDR      = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] to_mem_addr,
    input  logic [15:0] core_to_mem_data,
    input  logic        core_to_mem_write_enable,
    output logic [15:0] from_mem_data,
    output logic [15:0] io_out,
    output logic        io_strobe
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0]       r_mem [DEPTH];
    logic [15:0]       r_pipe [READ_LATENCY];
    logic [15:0]       r_ctr;
    logic [15:0]       r_io;
    logic              r_strobe;

    logic              w_sel_ctr;
    logic              w_sel_io;
    logic              w_wr_mem;
    logic              w_wr_io;
    logic [ADDR_W-1:0] w_idx;
    logic [15:0]       w_rd_data;

    // Upper address bits are ignored for storage, so words alias modulo DEPTH.
    assign w_sel_ctr = (to_mem_addr == CTR_ADDR);
    assign w_sel_io  = (to_mem_addr == IO_ADDR);
    assign w_idx     = to_mem_addr[ADDR_W-1:0];
    assign w_wr_mem  = core_to_mem_write_enable & ~reset & ~w_sel_ctr & ~w_sel_io;
    assign w_wr_io   = core_to_mem_write_enable & ~reset & w_sel_io;

    // Read mux; write-first on storage and I/O, the counter ignores writes.
    always_comb begin
        w_rd_data = 16'h0000;
        if (w_sel_ctr) begin
            w_rd_data = r_ctr;
        end else if (core_to_mem_write_enable) begin
            w_rd_data = core_to_mem_data;
        end else if (w_sel_io) begin
            w_rd_data = r_io;
        end else begin
            w_rd_data = r_mem[w_idx];
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_mem) begin
            r_mem[w_idx] <= core_to_mem_data;
        end
    end

    // Read pipeline; reset discards reads still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= 16'h0000;
            end
        end else begin
            r_pipe[0] <= w_rd_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Free-running cycle counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctr <= 16'h0000;
        end else begin
            r_ctr <= r_ctr + 16'h0001;
        end
    end

    // I/O register and its one-cycle write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_io     <= 16'h0000;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_wr_io;
            if (w_wr_io) begin
                r_io <= core_to_mem_data;
            end
        end
    end

    assign from_mem_data = r_pipe[READ_LATENCY-1];
    assign io_out        = r_io;
    assign io_strobe     = r_strobe;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with READ_LATENCY=1 and one
// with READ_LATENCY=3 share directed stimulus; monitors pop expectations per cycle.
module tb_mem_responder;

    typedef struct {
        int          due;
        logic        chk;
        logic [15:0] exp;
    } rd_e_t;

    typedef struct {
        int          due;
        logic [15:0] io;
        logic        stb;
    } io_e_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        we = 1'b0;

    logic [15:0] dout1, io1, dout3, io3;
    logic        stb1, stb3;

    int          edge_n = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic [15:0] ctr_m = 16'h0000;
    logic [15:0] io_m = 16'h0000;
    logic        stb_m = 1'b0;

    rd_e_t q1[$];
    rd_e_t q3[$];
    io_e_t qio1[$];
    io_e_t qio3[$];
    rd_e_t m1_e, m3_e;
    io_e_t mi1_e, mi3_e;

    mem_responder #(.ADDR_W(10), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .to_mem_addr(addr), .core_to_mem_data(wdata),
        .core_to_mem_write_enable(we), .from_mem_data(dout1), .io_out(io1), .io_strobe(stb1)
    );

    mem_responder #(.ADDR_W(10), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .to_mem_addr(addr), .core_to_mem_data(wdata),
        .core_to_mem_write_enable(we), .from_mem_data(dout3), .io_out(io3), .io_strobe(stb3)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_n, act, exp);
        end
    endtask

    // One stimulus cycle: drive inputs at negedge and queue expectations.
    task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w,
                       input logic r, input logic c, input logic [15:0] e);
        rd_e_t ent;
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = w;
        reset = r;
        if (r) begin
            foreach (q1[i]) if (q1[i].due >= edge_n + 1) begin q1[i].chk = 1'b1; q1[i].exp = 16'h0000; end
            foreach (q3[i]) if (q3[i].due >= edge_n + 1) begin q3[i].chk = 1'b1; q3[i].exp = 16'h0000; end
            ent.chk = 1'b1;
            ent.exp = 16'h0000;
            io_m    = 16'h0000;
            stb_m   = 1'b0;
            ctr_m   = 16'h0000;
        end else begin
            ent.chk = c;
            ent.exp = e;
            ctr_m   = ctr_m + 16'h0001;
            if (w && a == 16'hFFFF) begin
                io_m  = d;
                stb_m = 1'b1;
            end else begin
                stb_m = 1'b0;
            end
        end
        ent.due = edge_n + 1;
        q1.push_back(ent);
        ent.due = edge_n + 3;
        q3.push_back(ent);
        qio1.push_back('{edge_n + 1, io_m, stb_m});
        qio3.push_back('{edge_n + 1, io_m, stb_m});
    endtask

    initial forever begin
        @(negedge clk);
        while (q1.size() > 0 && q1[0].due < edge_n) void'(q1.pop_front());
        if (q1.size() > 0 && q1[0].due == edge_n) begin
            m1_e = q1.pop_front();
            if (m1_e.chk) chk16("rd_lat1", dout1, m1_e.exp);
        end
        while (qio1.size() > 0 && qio1[0].due < edge_n) void'(qio1.pop_front());
        if (qio1.size() > 0 && qio1[0].due == edge_n) begin
            mi1_e = qio1.pop_front();
            chk16("io_out_lat1", io1, mi1_e.io);
            chk16("io_strobe_lat1", {15'd0, stb1}, {15'd0, mi1_e.stb});
        end
    end

    initial forever begin
        @(negedge clk);
        while (q3.size() > 0 && q3[0].due < edge_n) void'(q3.pop_front());
        if (q3.size() > 0 && q3[0].due == edge_n) begin
            m3_e = q3.pop_front();
            if (m3_e.chk) chk16("rd_lat3", dout3, m3_e.exp);
        end
        while (qio3.size() > 0 && qio3[0].due < edge_n) void'(qio3.pop_front());
        if (qio3.size() > 0 && qio3[0].due == edge_n) begin
            mi3_e = qio3.pop_front();
            chk16("io_out_lat3", io3, mi3_e.io);
            chk16("io_strobe_lat3", {15'd0, stb3}, {15'd0, mi3_e.stb});
        end
    end

    initial begin
        repeat (3) cyc(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000);
        repeat (4) cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd4);
        // storage write, write-first and aliasing
        cyc(16'h0010, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'hBEEF);
        cyc(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        cyc(16'h0020, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h1234);
        cyc(16'h0020, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234);
        cyc(16'h0405, 16'hA5A5, 1'b1, 1'b0, 1'b1, 16'hA5A5);
        cyc(16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA5A5);
        cyc(16'hFFFE, 16'hDEAD, 1'b1, 1'b0, 1'b1, 16'd11);
        cyc(16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd12);
        // back-to-back I/O writes
        cyc(16'hFFFF, 16'h00FF, 1'b1, 1'b0, 1'b1, 16'h00FF);
        cyc(16'hFFFF, 16'h0F0F, 1'b1, 1'b0, 1'b1, 16'h0F0F);
        cyc(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0F0F);
        cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(16'h0001, 16'h1111, 1'b1, 1'b0, 1'b1, 16'h1111);
        cyc(16'h0002, 16'h2222, 1'b1, 1'b0, 1'b1, 16'h2222);
        cyc(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1111);
        cyc(16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h2222);
        cyc(16'h0410, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        // reset with three reads in flight and writes during reset
        cyc(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        cyc(16'h0020, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234);
        cyc(16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA5A5);
        cyc(16'hFFFF, 16'h7777, 1'b1, 1'b1, 1'b1, 16'h0000);
        cyc(16'h0020, 16'h9999, 1'b1, 1'b1, 1'b1, 16'h0000);
        cyc(16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd0);
        cyc(16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd1);
        cyc(16'h0020, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234);
        cyc(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000);
        cyc(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        // run the counter up to its wrap point
        while (ctr_m != 16'hFFFF) cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        cyc(16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000);
        repeat (5) cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
